button_conditioner: RTL and testbench

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

---
 rtl/button_conditioner.sv | 170 +++++++++++++++++
 tb/tb_button_conditioner.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: input synchroniser, stability-count debounce
// with press/release pulses, and per-channel auto-repeat while a button is held.
module button_conditioner #(
  parameter int CHANNELS     = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int LIMIT        = 40000000,
  parameter int REPEAT_DELAY = 50000000,
  parameter int REPEAT_RATE  = 10000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] button_in,
  input  logic [CHANNELS-1:0] repeat_en,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] repeat_pulse
);

  localparam int CNT_W   = $clog2(LIMIT);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LIMIT - 1);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] RATE_LAST   = REP_W'(REPEAT_RATE - 1);

  // State encoding is {level, synced}, so the state is derived rather than stored.
  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    RELEASE_WAIT = 2'b10,
    HELD         = 2'b11
  } chan_state_e;

  typedef enum logic {
    PH_DELAY = 1'b0,
    PH_RATE  = 1'b1
  } rep_phase_e;

  if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
    $error("button_conditioner: CHANNELS must be in 1..32");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("button_conditioner: SYNC_STAGES must be in 2..4");
  end
  if (LIMIT < 2) begin : g_bad_limit
    $error("button_conditioner: LIMIT must be at least 2");
  end
  if (REPEAT_DELAY < 2) begin : g_bad_delay
    $error("button_conditioner: REPEAT_DELAY must be at least 2");
  end
  if (REPEAT_RATE < 2) begin : g_bad_rate
    $error("button_conditioner: REPEAT_RATE must be at least 2");
  end

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    chan_state_e            state;
    logic                   accept;

    logic [CNT_W-1:0] stab_q, stab_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [REP_W-1:0] rep_target;
    rep_phase_e       phase_q, phase_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             rpt_q, rpt_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], button_in[ch]};
      end
    end

    assign synced     = sync_q[SYNC_STAGES-1];
    assign state      = chan_state_e'({level_q, synced});
    assign accept     = (state == PRESS_WAIT || state == RELEASE_WAIT) &&
                        (stab_q == STABLE_LAST);
    assign rep_target = (phase_q == PH_DELAY) ? DELAY_LAST : RATE_LAST;

    // NOTE: every output of this block gets a default first so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
      stab_d  = '0;
      level_d = level_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      rep_d   = rep_q;
      phase_d = phase_q;
      rpt_d   = 1'b0;

      case (state)
        IDLE, HELD: begin
          stab_d = '0;
        end
        PRESS_WAIT, RELEASE_WAIT: begin
          if (accept) begin
            level_d = synced;
            press_d = synced;
            rel_d   = ~synced;
          end else begin
            stab_d = stab_q + 1'b1;
          end
        end
        default: begin
          stab_d = '0;
        end
      endcase

      case (state)
        HELD: begin
          if (!repeat_en[ch]) begin
            rep_d   = '0;
            phase_d = PH_DELAY;
          end else if (rep_q == rep_target) begin
            rpt_d   = 1'b1;
            rep_d   = '0;
            phase_d = PH_RATE;
          end else begin
            rep_d = rep_q + 1'b1;
          end
        end
        RELEASE_WAIT: begin
          // A bounce during release keeps the repeat cadence; only an accepted release resets it.
          if (accept) begin
            rep_d   = '0;
            phase_d = PH_DELAY;
          end
        end
        default: begin
          rep_d   = '0;
          phase_d = PH_DELAY;
        end
      endcase
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        stab_q  <= '0;
        rep_q   <= '0;
        phase_q <= PH_DELAY;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        rpt_q   <= 1'b0;
      end else begin
        stab_q  <= stab_d;
        rep_q   <= rep_d;
        phase_q <= phase_d;
        level_q <= level_d;
        press_q <= press_d;
        rel_q   <= rel_d;
        rpt_q   <= rpt_d;
      end
    end

    assign level[ch]         = level_q;
    assign press[ch]         = press_q;
    assign release_pulse[ch] = rel_q;
    assign repeat_pulse[ch]  = rpt_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus random button
// activity, all compared every cycle against a run-length behavioural model.
module tb_button_conditioner;

  localparam int CH  = 4;
  localparam int SS  = 2;
  localparam int LIM = 4;
  localparam int RD  = 8;
  localparam int RR  = 3;
  localparam int LAT = SS + LIM;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] button_in;
  logic [CH-1:0] repeat_en;
  logic [CH-1:0] level;
  logic [CH-1:0] press;
  logic [CH-1:0] release_pulse;
  logic [CH-1:0] repeat_pulse;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: delayed input history, consecutive-disagreement run length,
  // and a count of enabled held cycles from which repeat instants follow arithmetically.
  logic [CH-1:0] m_lvl, m_press, m_rel, m_rpt;
  logic [CH-1:0] hist [$];
  int            run_len [CH];
  int            held_en [CH];
  int            seen_press [CH];
  int            seen_rel [CH];
  int            seen_rpt [CH];

  button_conditioner #(
    .CHANNELS    (CH),
    .SYNC_STAGES (SS),
    .LIMIT       (LIM),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE (RR)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .button_in    (button_in),
    .repeat_en    (repeat_en),
    .level        (level),
    .press        (press),
    .release_pulse(release_pulse),
    .repeat_pulse (repeat_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_lvl = '0; m_press = '0; m_rel = '0; m_rpt = '0;
    for (int c = 0; c < CH; c++) begin
      run_len[c] = 0;
      held_en[c] = 0;
    end
  endtask

  task automatic model_edge();
    logic [CH-1:0] s;
    logic          held;
    if (!reset) begin
      model_reset();
    end else begin
      s = (hist.size() >= SS) ? hist[SS-1] : '0;
      hist.push_front(button_in);
      if (hist.size() > SS) void'(hist.pop_back());
      m_press = '0; m_rel = '0; m_rpt = '0;
      for (int c = 0; c < CH; c++) begin
        held = m_lvl[c] && s[c];
        if (held) begin
          if (repeat_en[c]) begin
            held_en[c]++;
            if (held_en[c] == RD || (held_en[c] > RD && (held_en[c] - RD) % RR == 0))
              m_rpt[c] = 1'b1;
          end else begin
            held_en[c] = 0;
          end
        end
        if (s[c] != m_lvl[c]) begin
          run_len[c]++;
          if (run_len[c] == LIM) begin
            m_lvl[c]   = s[c];
            run_len[c] = 0;
            held_en[c] = 0;
            if (s[c]) m_press[c] = 1'b1;
            else      m_rel[c]   = 1'b1;
          end
        end else begin
          run_len[c] = 0;
        end
      end
    end
  endtask

  task automatic clear_seen();
    for (int c = 0; c < CH; c++) begin
      seen_press[c] = 0; seen_rel[c] = 0; seen_rpt[c] = 0;
    end
  endtask

  // One clock edge: advance the model, then compare all outputs 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("level",   32'(level),         32'(m_lvl));
    check("press",   32'(press),         32'(m_press));
    check("release", 32'(release_pulse), 32'(m_rel));
    check("repeat",  32'(repeat_pulse),  32'(m_rpt));
    for (int c = 0; c < CH; c++) begin
      if (press[c])         seen_press[c]++;
      if (release_pulse[c]) seen_rel[c]++;
      if (repeat_pulse[c])  seen_rpt[c]++;
    end
  endtask

  // kind: 0 press, 1 release, 2 repeat. n is the number of edges until the pulse (64 = none).
  task automatic wait_pulse(input int ch, input int kind, output int n);
    logic hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < 64) begin
      cycle();
      n++;
      case (kind)
        0:       hit = press[ch];
        1:       hit = release_pulse[ch];
        default: hit = repeat_pulse[ch];
      endcase
    end
  endtask

  // Called just after an edge: asserts reset between edges and checks the asynchronous clear.
  task automatic reset_mid_cycle(input int hold);
    #2 reset = 1'b0;
    #1;
    check("async_rst_level",   32'(level),         32'h0);
    check("async_rst_press",   32'(press),         32'h0);
    check("async_rst_release", 32'(release_pulse), 32'h0);
    check("async_rst_repeat",  32'(repeat_pulse),  32'h0);
    model_reset();
    repeat (hold) cycle();
    #2 reset = 1'b1;
  endtask

  initial begin
    int n;
    reset     = 1'b0;
    button_in = '0;
    repeat_en = '0;
    model_reset();
    clear_seen();
    repeat (3) cycle();
    check("reset_state", 32'({level, press, release_pulse, repeat_pulse}), 32'h0);
    #2 reset = 1'b1;

    // Clean press on ch0.
    button_in[0] = 1'b1;
    wait_pulse(0, 0, n);
    check("press_latency_ch0", n, LAT);
    check("press_only_ch0", 32'(press), 32'h1);
    check("level_ch0", 32'(level), 32'h1);
    cycle();
    check("press_drop_ch0", 32'(press), 32'h0);

    // Bounce on ch1: 3 high, 1 low, then steady high.
    clear_seen();
    button_in[1] = 1'b1;
    repeat (3) cycle();
    button_in[1] = 1'b0;
    cycle();
    button_in[1] = 1'b1;
    wait_pulse(1, 0, n);
    check("bounce_latency_ch1", n, LAT);
    check("bounce_single_press", seen_press[1], 1);

    // Auto-repeat on ch2.
    repeat_en[0] = 1'b1;
    repeat_en[2] = 1'b1;
    button_in[2] = 1'b1;
    wait_pulse(2, 0, n);
    check("press_latency_ch2", n, LAT);
    wait_pulse(2, 2, n);
    check("first_repeat_delay", n, RD);
    wait_pulse(2, 2, n);
    check("repeat_rate_1", n, RR);
    wait_pulse(2, 2, n);
    check("repeat_rate_2", n, RR);
    repeat (RR - 1) cycle();
    repeat_en[2] = 1'b0;
    clear_seen();
    repeat (12) cycle();
    check("repeat_stopped", seen_rpt[2], 0);
    repeat_en[2] = 1'b1;
    wait_pulse(2, 2, n);
    check("repeat_restart_delay", n, RD);

    // Release of ch0 after a long hold.
    button_in[0] = 1'b0;
    wait_pulse(0, 1, n);
    check("release_latency_ch0", n, LAT);
    check("release_level_ch0", 32'(level[0]), 32'h0);
    clear_seen();
    repeat (20) cycle();
    check("no_repeat_after_release", seen_rpt[0], 0);
    check("single_release_ch0", seen_rel[0], 0);

    // Simultaneous press on all channels, then staggered releases.
    button_in = '0;
    repeat_en = '0;
    repeat (LAT + 4) cycle();
    check("all_idle", 32'(level), 32'h0);
    button_in = '1;
    wait_pulse(0, 0, n);
    check("press_latency_all", n, LAT);
    check("press_all", 32'(press), 32'hF);
    cycle();
    check("press_all_drop", 32'(press), 32'h0);
    clear_seen();
    button_in[0] = 1'b0;
    cycle();
    button_in[1] = 1'b0;
    cycle();
    button_in[2] = 1'b0;
    repeat (2) cycle();
    button_in[3] = 1'b0;
    repeat (LAT + 4) cycle();
    for (int c = 0; c < CH; c++) check($sformatf("stagger_release_ch%0d", c), seen_rel[c], 1);
    check("stagger_level", 32'(level), 32'h0);

    // Reset during PRESS_WAIT at count 2, then reset while a press pulse is high.
    button_in[3] = 1'b1;
    repeat (4) cycle();
    check("press_wait_level", 32'(level), 32'h0);
    reset_mid_cycle(2);
    wait_pulse(3, 0, n);
    check("press_after_reset", n, LAT);
    reset_mid_cycle(1);
    clear_seen();
    wait_pulse(3, 0, n);
    check("press_after_pulse_reset", n, LAT);
    check("no_residual_press", seen_press[3], 1);

    // Random activity with occasional resets.
    for (int t = 0; t < 4000; t++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(11) == 0) button_in[c] = ~button_in[c];
        if ($urandom_range(59) == 0) repeat_en[c] = ~repeat_en[c];
      end
      if ($urandom_range(999) == 0) reset_mid_cycle(int'($urandom_range(2)));
      else cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
